// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - multi-cycle unsigned multiply / divide / modulo sequencer
//
// Purpose: shift-add multiplier (one multiplier bit per cycle, LSB first) and
// restoring divider (one quotient bit per cycle, MSB first) for the ALU
// control codes MUL, DIV and MOD. Divide-by-zero and unsupported codes finish
// one cycle after accept with o_err set.
//
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   i_valid  request valid, accepted when o_ready is high and i_kill is low
//   o_ready  high only while idle
//   i_ctl    ALU control code (CTL_MUL / CTL_DIV / CTL_MOD)
//   i_op1    multiplicand / dividend
//   i_op2    multiplier / divisor
//   i_kill   abort in-flight operation, blocks accept while idle
//   o_done   one-cycle pulse qualifying o_res / o_err
//   o_res    result, held until the next completed operation
//   o_err    unsupported code or divide by zero
module muldiv_seq #(
  parameter int         XLEN    = 32,
  parameter logic [3:0] CTL_MUL = 4'd9,   // encodings must match defs.v
  parameter logic [3:0] CTL_DIV = 4'd10,
  parameter logic [3:0] CTL_MOD = 4'd11
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [3:0]      i_ctl,
  input  logic [XLEN-1:0] i_op1,
  input  logic [XLEN-1:0] i_op2,
  input  logic            i_kill,
  output logic            o_done,
  output logic [XLEN-1:0] o_res,
  output logic            o_err
);

  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t          r_state, w_next;
  logic [XLEN-1:0] r_a;        // multiplicand (shifts left) / dividend-quotient
  logic [XLEN-1:0] r_b;        // multiplier (shifts right) / divisor
  logic [XLEN:0]   r_acc;      // product accumulator / partial remainder
  logic [CW-1:0]   r_cnt;
  logic            r_mul, r_mod;
  logic [XLEN-1:0] r_out, r_res;
  logic            r_out_err, r_err;

  logic            w_accept, w_is_mul, w_is_div, w_is_mod, w_fast;
  logic [XLEN-1:0] w_fast_res, w_quo, w_step_res;
  logic [XLEN:0]   w_acc_mul, w_shift, w_rem;
  logic [XLEN+1:0] w_sub;

  assign w_accept = (r_state == S_IDLE) && i_valid && !i_kill;
  assign w_is_mul = (i_ctl == CTL_MUL);
  assign w_is_div = (i_ctl == CTL_DIV);
  assign w_is_mod = (i_ctl == CTL_MOD);
  assign w_fast   = !(w_is_mul || w_is_div || w_is_mod) ||
                    ((w_is_div || w_is_mod) && (i_op2 == '0));
  assign w_fast_res = w_is_div ? '1 : (w_is_mod ? i_op1 : '0);

  // Multiply step: only the low XLEN bits matter, the carry into the top bit
  // of the accumulator is harmless.
  assign w_acc_mul = r_acc + {1'b0, (r_b[0] ? r_a : '0)};

  // Restoring divide step: shift the next dividend bit into the remainder and
  // subtract the divisor; the extra top bit of w_sub is the borrow.
  assign w_shift = {r_acc[XLEN-1:0], r_a[XLEN-1]};
  assign w_sub   = {1'b0, w_shift} - {2'b00, r_b};
  assign w_rem   = w_sub[XLEN+1] ? w_shift : w_sub[XLEN:0];
  assign w_quo   = {r_a[XLEN-2:0], ~w_sub[XLEN+1]};

  assign w_step_res = r_mul ? w_acc_mul[XLEN-1:0] :
                      (r_mod ? w_rem[XLEN-1:0] : w_quo);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = w_fast ? S_FIN : S_RUN;
      S_RUN: begin
        if (i_kill)                w_next = S_IDLE;
        else if (r_cnt == CW'(1))  w_next = S_FIN;
      end
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs: the fresh result is shown during FIN and committed to r_res on
  // leaving FIN, so a kill in FIN leaves the visible result untouched.
  always_comb begin
    o_ready = (r_state == S_IDLE);
    o_done  = (r_state == S_FIN) && !i_kill;
    o_res   = o_done ? r_out : r_res;
    o_err   = o_done ? r_out_err : r_err;
  end

  // Datapath
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_mul     <= 1'b0;
      r_mod     <= 1'b0;
      r_out     <= '0;
      r_out_err <= 1'b0;
      r_res     <= '0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a   <= i_op1;
            r_b   <= i_op2;
            r_acc <= '0;
            r_cnt <= CW'(XLEN);
            r_mul <= w_is_mul;
            r_mod <= w_is_mod;
            if (w_fast) begin
              r_out     <= w_fast_res;
              r_out_err <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (!i_kill) begin
            if (r_mul) begin
              r_acc <= w_acc_mul;
              r_a   <= r_a << 1;
              r_b   <= r_b >> 1;
            end else begin
              r_acc <= w_rem;
              r_a   <= w_quo;
            end
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
              r_out     <= w_step_res;
              r_out_err <= 1'b0;
            end
          end
        end
        S_FIN: begin
          if (!i_kill) begin
            r_res <= r_out;
            r_err <= r_out_err;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - self-checking bench for muldiv_seq
module tb_muldiv_seq;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_MUL = 4'd9;
  localparam logic [3:0] ALU_DIV = 4'd10;
  localparam logic [3:0] ALU_MOD = 4'd11;

  logic        clk, rst_n, valid, kill;
  logic [3:0]  ctl;
  logic [31:0] op1, op2;
  logic        ready, done, err;
  logic [31:0] res;

  int tests = 0;
  int fails = 0;

  muldiv_seq #(.XLEN(32), .CTL_MUL(ALU_MUL), .CTL_DIV(ALU_DIV), .CTL_MOD(ALU_MOD)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(ready),
    .i_ctl(ctl), .i_op1(op1), .i_op2(op2), .i_kill(kill),
    .o_done(done), .o_res(res), .o_err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Reference: {err, result} from plain arithmetic.
  function automatic logic [32:0] model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    if (c == ALU_MUL) return {1'b0, a * b};
    if (c == ALU_DIV) return (b == 0) ? {1'b1, 32'hFFFF_FFFF} : {1'b0, a / b};
    if (c == ALU_MOD) return (b == 0) ? {1'b1, a} : {1'b0, a % b};
    return {1'b1, 32'h0};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [32:0] m;
    logic [31:0] old;
    int lat;
    m   = model(c, a, b);
    old = res;
    @(negedge clk);
    chk({tag, " ready_before"}, 64'(ready), 64'd1);
    valid = 1'b1; ctl = c; op1 = a; op2 = b;
    @(posedge clk); #1;
    valid = 1'b0;
    ctl = 4'($urandom); op1 = $urandom; op2 = $urandom;
    lat = 0;
    while (!done && lat < 40) begin
      chk({tag, " ready_low"}, 64'(ready), 64'd0);
      chk({tag, " res_held"}, 64'(res), 64'(old));
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " done"}, 64'(done), 64'd1);
    chk({tag, " latency"}, 64'(lat), m[32] ? 64'd0 : 64'd32);
    chk({tag, " res"}, 64'(res), 64'(m[31:0]));
    chk({tag, " err"}, 64'(err), 64'(m[32]));
    chk({tag, " ready_in_fin"}, 64'(ready), 64'd0);
    @(posedge clk); #1;
    chk({tag, " done_pulse"}, 64'(done), 64'd0);
    chk({tag, " ready_after"}, 64'(ready), 64'd1);
    chk({tag, " res_kept"}, 64'(res), 64'(m[31:0]));
  endtask

  initial begin : main
    logic [31:0] old;
    logic [3:0]  qc[4];
    logic [31:0] qa[4], qb[4];
    logic [32:0] m;
    int idx, ndone, cyc, prev, seen;
    logic acc;

    rst_n = 1'b0; valid = 1'b0; kill = 1'b0; ctl = ALU_MUL; op1 = 0; op2 = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset ready", 64'(ready), 64'd1);
    chk("reset done", 64'(done), 64'd0);
    chk("reset res", 64'(res), 64'd0);
    chk("reset err", 64'(err), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    run_op(ALU_MUL, 7, 6, "mul7x6");
    run_op(ALU_MUL, 32'hFFFF_FFFF, 2, "mul_ovf");
    run_op(ALU_MUL, 32'h0001_0000, 32'h0001_0000, "mul_wrap");
    run_op(ALU_DIV, 100, 7, "div100_7");
    run_op(ALU_MOD, 100, 7, "mod100_7");
    run_op(ALU_DIV, 32'h8000_0000, 1, "div_msb");
    run_op(ALU_DIV, 5, 9, "div5_9");
    run_op(ALU_MOD, 5, 9, "mod5_9");
    run_op(ALU_DIV, 123, 0, "div_by0");
    run_op(ALU_MOD, 123, 0, "mod_by0");
    run_op(ALU_ADD, 11, 22, "unsupported");
    run_op(ALU_MUL, 12, 13, "mul12x13");

    // Kill at RUN cycle 10
    old = res;
    @(negedge clk); valid = 1'b1; ctl = ALU_MUL; op1 = 5; op2 = 5;
    @(posedge clk); #1; valid = 1'b0;
    repeat (10) @(posedge clk);
    #1; kill = 1'b1;
    @(posedge clk); #1; kill = 1'b0;
    chk("kill ready", 64'(ready), 64'd1);
    chk("kill res", 64'(res), 64'(old));
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (done) seen++; end
    chk("kill no_done", 64'(seen), 64'd0);
    run_op(ALU_MUL, 3, 3, "mul_after_kill");

    // Kill in FIN suppresses o_done and keeps old result
    old = res;
    @(negedge clk); valid = 1'b1; ctl = ALU_MUL; op1 = 7; op2 = 7;
    @(posedge clk); #1; valid = 1'b0;
    repeat (32) @(posedge clk);
    #1; kill = 1'b1; #1;
    chk("killfin done", 64'(done), 64'd0);
    chk("killfin res", 64'(res), 64'(old));
    @(posedge clk); #1; kill = 1'b0;
    chk("killfin ready", 64'(ready), 64'd1);
    chk("killfin res_after", 64'(res), 64'(old));

    // Kill in IDLE blocks accept
    @(negedge clk); valid = 1'b1; kill = 1'b1; ctl = ALU_MUL; op1 = 2; op2 = 2;
    @(posedge clk); #1;
    chk("idlekill ready", 64'(ready), 64'd1);
    valid = 1'b0; kill = 1'b0;

    // Reset mid-RUN
    run_op(ALU_MUL, 9, 9, "mul_pre_reset");
    @(negedge clk); valid = 1'b1; ctl = ALU_DIV; op1 = 100; op2 = 7;
    @(posedge clk); #1; valid = 1'b0;
    repeat (5) @(posedge clk);
    #1; rst_n = 1'b0; #1;
    chk("rst_mid ready", 64'(ready), 64'd1);
    chk("rst_mid done", 64'(done), 64'd0);
    chk("rst_mid res", 64'(res), 64'd0);
    chk("rst_mid err", 64'(err), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (done) seen++; end
    chk("rst_mid no_done", 64'(seen), 64'd0);

    // Back-to-back with i_valid held high
    qc[0] = ALU_MUL; qa[0] = 1234;  qb[0] = 5678;
    qc[1] = ALU_DIV; qa[1] = 99999; qb[1] = 37;
    qc[2] = ALU_MOD; qa[2] = 99999; qb[2] = 37;
    qc[3] = ALU_MUL; qa[3] = $urandom; qb[3] = $urandom;
    idx = 0; ndone = 0; cyc = 0; prev = 0;
    @(negedge clk); valid = 1'b1; ctl = qc[0]; op1 = qa[0]; op2 = qb[0];
    while (ndone < 4 && cyc < 200) begin
      acc = ready && valid;
      @(posedge clk); #1; cyc++;
      if (acc) begin
        idx++;
        if (idx < 4) begin ctl = qc[idx]; op1 = qa[idx]; op2 = qb[idx]; end
        else valid = 1'b0;
      end
      if (done) begin
        m = model(qc[ndone], qa[ndone], qb[ndone]);
        chk($sformatf("b2b%0d res", ndone), 64'(res), 64'(m[31:0]));
        chk($sformatf("b2b%0d err", ndone), 64'(err), 64'(m[32]));
        chk($sformatf("b2b%0d ready", ndone), 64'(ready), 64'd0);
        if (ndone > 0) chk($sformatf("b2b%0d spacing", ndone), 64'(cyc - prev), 64'd34);
        prev = cyc;
        ndone++;
      end
      @(negedge clk);
    end
    valid = 1'b0;
    chk("b2b count", 64'(ndone), 64'd4);
    repeat (3) @(posedge clk);
    #1;

    // Randomized operations against the reference model
    for (int i = 0; i < 24; i++) begin
      logic [3:0]  c;
      logic [31:0] a, b;
      case ($urandom_range(0, 9))
        0:             c = ALU_ADD;
        1, 2, 3:       c = ALU_MUL;
        4, 5, 6:       c = ALU_DIV;
        default:       c = ALU_MOD;
      endcase
      a = $urandom;
      if ($urandom_range(0, 7) == 0)      b = 0;
      else if ($urandom_range(0, 1) == 1) b = $urandom;
      else                                b = $urandom_range(1, 1000);
      run_op(c, a, b, $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
